add_round_key: RTL and testbench
================================

Name: add_round_key

Overview:
- Downstream neighbour of mix_cols in the AES encryption datapath.
- Consumes the 128-bit mix_cols result on its i_en/o_en strobe and XORs it with the round key for the current round.
- Holds a local bank of NR+1 round keys written by the key-expansion logic, tracks the round number, and flags block completion after the final round.
- Also serves the initial whitening step (round 0) and the final round (no mix_cols upstream; the caller feeds shift_rows output directly).

Parameters:
- NR, 10: number of AES rounds. Key bank depth is NR+1; round counter range is 0..NR.
- DW, 128: state/key width in bits. Fixed at 128 for AES; exists for bench readability.

Ports:
- clk  in  1: rising-edge clock.
- rst  in  1: asynchronous, active-low reset (asserted when 0).
- data_in  in  DW: state from the upstream stage.
- i_en  in  1: data_in valid; one block-round per high cycle.
- blk_start  in  1: synchronous; clears the round counter to 0 for a new block.
- key_we  in  1: round-key write strobe.
- key_addr  in  4: round-key index 0..NR.
- key_data  in  DW: round key to write.
- data_out  out  DW: registered result data_in ^ rk[round].
- o_en  out  1: one-cycle pulse marking data_out valid.
- round  out  4: current round counter (the round the next i_en uses).
- blk_done  out  1: one-cycle pulse coincident with the o_en of round NR.

Behaviour:
- Reset (rst=0, asynchronous):
  - data_out=0, o_en=0, blk_done=0, round=0.
  - All key-bank entries are cleared to 0.
- Latency: i_en high at edge t → at edge t+1, data_out = data_in ^ rk[round], o_en=1 for exactly one cycle.
- data_out holds its last value while o_en=0.
- Back-to-back i_en is legal, giving one result per cycle; there is no backpressure.
- Round counter:
  - Each accepted i_en increments round.
  - An i_en with round==NR produces blk_done=1 alongside o_en, and round wraps to 0.
- blk_start:
  - Sets round=0 at the next edge.
  - blk_start and i_en in the same cycle: the i_en uses round 0 and round becomes 1 (0 if NR==0).
- State machine, encoded by round: IDLE (round==0, no block in progress) → ROUND (1..NR-1) → LAST (NR) → IDLE via wrap.
  - blk_start forces IDLE from any state.
  - A block in progress is abandoned without any flag.
- Key bank:
  - key_we writes key_data into rk[key_addr] at the edge.
  - key_addr > NR: the write is ignored.
  - A write and an i_en reading the same index in the same cycle: the XOR uses the old key; the new key is visible from the next cycle.
- Reset mid-block: all state is lost immediately; o_en drops asynchronously. The bench must re-load keys afterwards.
- No arithmetic other than 128-bit bitwise XOR; no width extension.

Optional Feature:
- Macro ARK_KEY_LOCK_EN.
- When defined:
  - Key writes are refused while a block is in progress (round != 0). The bank is unchanged.
  - Extra output port key_err (1 bit, reset 0) pulses for one cycle on each refused write.
  - A write in the same cycle as blk_start is accepted.
- When undefined:
  - Writes are always accepted per the rules above.
  - The key_err port does not exist.

Test Plan:
- Reset/default: hold rst=0 with i_en toggling → data_out=0, o_en=0, round=0, blk_done=0. Release rst, then i_en with data_in=0xffff…ff → data_out=0xffff…ff (key bank cleared).
- Round 0 whitening: rk[0]=2b7e151628aed2a6abf7158809cf4f3c; blk_start, then i_en with data_in=3243f6a8885a308d313198a2e0370734 → one cycle later data_out=193de3bea0f4e22b9ac68d2ae9f84808, o_en=1, round=1.
- Round 1: rk[1]=a0fafe1788542cb123a339392a6c7605; i_en with data_in=046681e5e0cb199a48f8d37a2806264c → data_out=a49c7ff2689f352b6b5bea43026a5049, round=2.
- Full block and wrap: 11 back-to-back i_en after blk_start → 11 consecutive o_en pulses; blk_done only on the 11th; round returns to 0.
- Collisions:
  - key_we to rk[3] in the same cycle as an i_en at round 3 → the result uses the old rk[3].
  - blk_start together with i_en at round 7 → the result uses rk[0] and round=1.
  - key_addr=12 write → bank unchanged.
- ARK_KEY_LOCK_EN defined: key_we at round=4 → bank unchanged, key_err pulses once. The same write at round=0 → accepted, key_err=0.

Source files
------------

// File: rtl/add_round_key.sv
// AES AddRoundKey stage: XORs the incoming state with the round key for the
// current round and holds a local bank of NR+1 round keys. It also tracks the
// round number and flags the end of each block. Define ARK_KEY_LOCK_EN to
// refuse key writes while a block is in progress; refused writes pulse key_err.
module add_round_key #(
  parameter int NR = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  input  logic          i_en,
  input  logic          blk_start,
  input  logic          key_we,
  input  logic [3:0]    key_addr,
  input  logic [DW-1:0] key_data,
  output logic [DW-1:0] data_out,
  output logic          o_en,
  output logic [3:0]    round,
`ifdef ARK_KEY_LOCK_EN
  output logic          key_err,
`endif
  output logic          blk_done
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // The block phase is fully determined by the round counter.
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ROUND,
    PH_LAST
  } phase_e;

  logic [DW-1:0] rk [0:NR];
  logic [3:0]    use_round;
  logic [3:0]    round_next;
  logic          blk_done_next;
  logic          key_in_range;
  logic          key_wr;
  phase_e        phase;

  // blk_start wins over a block in progress, including for an i_en in the same cycle.
  assign use_round    = blk_start ? 4'd0 : round;
  assign key_in_range = (key_addr <= LAST_ROUND);

`ifdef ARK_KEY_LOCK_EN
  logic key_locked;

  assign key_locked = (round != 4'd0) && !blk_start;
  assign key_wr     = key_we && key_in_range && !key_locked;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_err <= 1'b0;
    end else begin
      key_err <= key_we && key_locked;
    end
  end
`else
  assign key_wr = key_we && key_in_range;
`endif

  always_comb begin
    if (use_round == LAST_ROUND) begin
      phase = PH_LAST;
    end else if (use_round == 4'd0) begin
      phase = PH_IDLE;
    end else begin
      phase = PH_ROUND;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise latches are inferred.
    round_next    = round;
    blk_done_next = 1'b0;
    if (i_en) begin
      case (phase)
        PH_LAST: begin
          round_next    = 4'd0;
          blk_done_next = 1'b1;
        end
        default: round_next = use_round + 4'd1;
      endcase
    end else if (blk_start) begin
      round_next = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      round    <= 4'd0;
      blk_done <= 1'b0;
      o_en     <= 1'b0;
      data_out <= '0;
    end else begin
      round    <= round_next;
      blk_done <= blk_done_next;
      o_en     <= i_en;
      if (i_en) begin
        data_out <= data_in ^ rk[use_round];
      end
    end
  end

  // A same-cycle write and read of one entry sees the old key, since the bank is read before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the key bank is reset on purpose so a fresh block never XORs with stale keys.
      for (int i = 0; i <= NR; i++) begin
        rk[i] <= '0;
      end
    end else if (key_wr) begin
      rk[key_addr] <= key_data;
    end
  end

endmodule

// File: tb/tb_add_round_key.sv
// Directed self-checking bench for add_round_key, including collisions, the
// out-of-range key write, and the key lock when ARK_KEY_LOCK_EN is defined.
module tb_add_round_key;

  localparam int NR = 10;
  localparam int DW = 128;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          i_en;
  logic          blk_start;
  logic          key_we;
  logic [3:0]    key_addr;
  logic [DW-1:0] key_data;
  logic [DW-1:0] data_out;
  logic          o_en;
  logic [3:0]    round;
  logic          blk_done;
`ifdef ARK_KEY_LOCK_EN
  logic          key_err;
`endif

  logic [DW-1:0] model_rk [0:NR];
  int n_checks;
  int n_errors;

  add_round_key #(.NR(NR), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .i_en      (i_en),
    .blk_start (blk_start),
    .key_we    (key_we),
    .key_addr  (key_addr),
    .key_data  (key_data),
    .data_out  (data_out),
    .o_en      (o_en),
    .round     (round),
`ifdef ARK_KEY_LOCK_EN
    .key_err   (key_err),
`endif
    .blk_done  (blk_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [3:0] addr, input logic [DW-1:0] d);
    key_we   = 1'b1;
    key_addr = addr;
    key_data = d;
    tick();
    key_we   = 1'b0;
  endtask

  function automatic logic [DW-1:0] pattern(input int i);
    return 128'h3243f6a8885a308d313198a2e0370734 ^ {16{8'(i * 29 + 1)}};
  endfunction

  // Starts a fresh block and runs all NR+1 rounds back to back against the model.
  task automatic run_block(input string tag);
    blk_start = 1'b1;
    tick();
    blk_start = 1'b0;
    for (int i = 0; i <= NR; i++) begin
      i_en    = 1'b1;
      data_in = pattern(i + 7);
      tick();
      check($sformatf("%s_data%0d", tag, i), data_out, pattern(i + 7) ^ model_rk[i]);
      check($sformatf("%s_oen%0d", tag, i), 128'(o_en), 128'(1));
      check($sformatf("%s_done%0d", tag, i), 128'(blk_done), 128'(i == NR));
      check($sformatf("%s_round%0d", tag, i), 128'(round), 128'((i + 1) % (NR + 1)));
    end
    i_en = 1'b0;
    tick();
    check({tag, "_oen_idle"}, 128'(o_en), 128'(0));
    check({tag, "_done_idle"}, 128'(blk_done), 128'(0));
    check({tag, "_round_end"}, 128'(round), 128'(0));
  endtask

  initial begin
    logic [DW-1:0] held;
    logic [DW-1:0] new_k;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    data_in   = '0;
    i_en      = 1'b0;
    blk_start = 1'b0;
    key_we    = 1'b0;
    key_addr  = '0;
    key_data  = '0;
    for (int i = 0; i <= NR; i++) model_rk[i] = '0;

    // Reset held while i_en toggles.
    for (int i = 0; i < 4; i++) begin
      i_en    = (i % 2 == 0);
      data_in = pattern(i);
      tick();
      check("rst_data", data_out, '0);
      check("rst_oen", 128'(o_en), 128'(0));
      check("rst_round", 128'(round), 128'(0));
      check("rst_done", 128'(blk_done), 128'(0));
    end
    i_en = 1'b0;
    rst  = 1'b1;
    tick();

    // Cleared bank passes data through unchanged.
    i_en    = 1'b1;
    data_in = '1;
    tick();
    i_en = 1'b0;
    check("clr_data", data_out, '1);
    check("clr_oen", 128'(o_en), 128'(1));
    check("clr_round", 128'(round), 128'(1));

    blk_start = 1'b1;
    tick();
    blk_start = 1'b0;
    model_rk[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_rk[1] = 128'ha0fafe1788542cb123a339392a6c7605;
    for (int i = 2; i <= NR; i++) model_rk[i] = {4{32'(i) * 32'h9e3779b9}};
    for (int i = 0; i <= NR; i++) write_key(4'(i), model_rk[i]);

    // Round 0 whitening and round 1 with FIPS-197 vectors.
    blk_start = 1'b1;
    tick();
    blk_start = 1'b0;
    i_en      = 1'b1;
    data_in   = 128'h3243f6a8885a308d313198a2e0370734;
    tick();
    i_en = 1'b0;
    check("r0_data", data_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("r0_oen", 128'(o_en), 128'(1));
    check("r0_round", 128'(round), 128'(1));
    tick();
    check("hold_oen", 128'(o_en), 128'(0));
    check("hold_data", data_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    i_en    = 1'b1;
    data_in = 128'h046681e5e0cb199a48f8d37a2806264c;
    tick();
    i_en = 1'b0;
    check("r1_data", data_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
    check("r1_round", 128'(round), 128'(2));

    run_block("blk1");

    // Write to rk[3] in the same cycle as the i_en that reads it.
    blk_start = 1'b1;
    tick();
    blk_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_en    = 1'b1;
      data_in = pattern(40 + i);
      tick();
      check("pre3_data", data_out, pattern(40 + i) ^ model_rk[i]);
    end
    new_k    = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    i_en     = 1'b1;
    data_in  = pattern(50);
    key_we   = 1'b1;
    key_addr = 4'd3;
    key_data = new_k;
    tick();
    i_en   = 1'b0;
    key_we = 1'b0;
    check("coll_old_key", data_out, pattern(50) ^ model_rk[3]);
    check("coll_round", 128'(round), 128'(4));
`ifdef ARK_KEY_LOCK_EN
    check("lock_err_r3", 128'(key_err), 128'(1));
`else
    model_rk[3] = new_k;
`endif

    // Key write with no i_en at round 4.
    write_key(4'd5, 128'hdeadbeef00112233445566778899aabb);
`ifdef ARK_KEY_LOCK_EN
    check("lock_err_r4", 128'(key_err), 128'(1));
    tick();
    check("lock_err_pulse", 128'(key_err), 128'(0));
`else
    model_rk[5] = 128'hdeadbeef00112233445566778899aabb;
`endif
    for (int i = 4; i < 7; i++) begin
      i_en    = 1'b1;
      data_in = pattern(60 + i);
      tick();
      check("mid_data", data_out, pattern(60 + i) ^ model_rk[i]);
    end
    check("mid_round7", 128'(round), 128'(7));

    // blk_start together with i_en at round 7 abandons the block.
    blk_start = 1'b1;
    i_en      = 1'b1;
    data_in   = pattern(77);
    tick();
    blk_start = 1'b0;
    i_en      = 1'b0;
    check("restart_data", data_out, pattern(77) ^ model_rk[0]);
    check("restart_round", 128'(round), 128'(1));
    check("restart_done", 128'(blk_done), 128'(0));

    // Out-of-range write at round 0 leaves the bank untouched.
    blk_start = 1'b1;
    tick();
    blk_start = 1'b0;
    write_key(4'd12, 128'hffffffff00000000ffffffff00000000);
`ifdef ARK_KEY_LOCK_EN
    // Same write as before, now at round 0: accepted without an error.
    write_key(4'd5, 128'hdeadbeef00112233445566778899aabb);
    check("lock_ok_err", 128'(key_err), 128'(0));
    model_rk[5] = 128'hdeadbeef00112233445566778899aabb;
`endif
    run_block("blk2");

    // Asynchronous reset mid-block.
    blk_start = 1'b1;
    tick();
    blk_start = 1'b0;
    i_en      = 1'b1;
    data_in   = pattern(90);
    tick();
    i_en = 1'b0;
    check("pre_arst_oen", 128'(o_en), 128'(1));
    #2 rst = 1'b0;
    #1;
    check("arst_oen", 128'(o_en), 128'(0));
    check("arst_data", data_out, '0);
    check("arst_round", 128'(round), 128'(0));
    #1 rst = 1'b1;
    held      = pattern(91);
    blk_start = 1'b1;
    i_en      = 1'b1;
    data_in   = held;
    tick();
    blk_start = 1'b0;
    i_en      = 1'b0;
    check("arst_bank_clr", data_out, held);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
